winner_tree_decoder: RTL and testbench
======================================

# winner_tree_decoder

Consumes the per-node index codes produced by the pairwise max-comparator tree that selects the winning neuron. It walks the tree from root to leaf, one level per cycle, to recover the winning neuron ID. It then applies a firing threshold and issues a req/ack update request with a one-hot neuron enable to the neuron array. It sits between the argmax comparator tree and the weight/threshold update logic.

## Interface
- `p_width`, 21, width of the winner magnitude and threshold.
- `p_levels`, 3, tree depth; the tree has N = 2**p_levels leaves and N-1 nodes.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  tree result valid.
- `o_ready`  out  1  high in IDLE; accept occurs on an edge with i_valid && o_ready.
- `i_node_idx`  in  2*(N-1)  node codes, heap order.
  - Node k occupies bits [2k+1:2k]; node 0 is the root.
  - Children of node k: 2k+1 is the a-side, 2k+2 is the b-side.
  - Code 01 = a won, 10 = b won, 00 = both inputs zero, 11 = illegal.
- `i_value`  in  p_width  winning magnitude (root result).
- `i_thresh`  in  p_width  firing threshold.
- `o_upd_req`  out  1  update request; held until acknowledged.
- `i_upd_ack`  in  1  update acknowledge from the neuron array.
- `o_winner_id`  out  p_levels  decoded winner ID.
- `o_onehot`  out  N  one-hot of o_winner_id; nonzero only while o_upd_req=1.
- `o_done`  out  1  one-cycle completion pulse.
- `o_nowin`  out  1  no winner (all-zero tree, or value below threshold).
- `o_err`  out  1  malformed path.

## Operation
- States are IDLE, WALK and REQ.
- **IDLE**
  - o_ready=1.
  - On accept, register i_node_idx.
  - Register the flag below = (i_value < i_thresh), unsigned compare.
  - Clear the ID accumulator, set ptr=0, set lvl=0, clear the error/zero flags, go WALK.
  - o_winner_id, o_nowin and o_err keep their previous values until the accept edge, where they are cleared.
- **WALK**: each cycle, examine code c at node ptr.
  - c=01: id = {id[p_levels-2:0],0}, ptr = 2*ptr+1.
  - c=10: id = {id[p_levels-2:0],1}, ptr = 2*ptr+2.
  - c=00 at lvl=0: set the zero flag.
  - c=00 at lvl>0, or c=11 at any level: set the sticky error flag.
  - Once zero or error is set, id and ptr freeze and the remaining levels still consume cycles. Latency is fixed.
  - After lvl = p_levels-1:
    - **Error:** o_err=1, o_done pulse, go IDLE.
    - **Else zero or below:** o_nowin=1, o_done pulse, go IDLE.
    - **Else:** load o_winner_id, assert o_upd_req, drive o_onehot = 1<<id, go REQ.
  - Error has priority over nowin.
- **REQ**
  - o_upd_req, o_winner_id and o_onehot are held stable.
  - On an edge with i_upd_ack=1: deassert o_upd_req, zero o_onehot, pulse o_done next cycle, go IDLE.
- i_upd_ack is ignored outside REQ.
- i_valid is ignored outside IDLE; the upstream source must hold its data until accepted.
- o_winner_id retains the last decoded ID after REQ until the next accept.

## Timing
- Reset (sync):
  - State IDLE, o_ready=1.
  - o_upd_req, o_done, o_nowin and o_err = 0.
  - o_winner_id = 0, o_onehot = 0.
  - Internal registers cleared.
- Reset mid-WALK or mid-REQ aborts the walk immediately, with no o_done.
  - A pending request is dropped; the neuron array must treat req falling without ack as cancel.
- Accept at edge E0 causes:
  - WALK steps at edges E1..E(p_levels).
  - Result registered at E(p_levels), so it is visible in the cycle after it.
  - For p_levels=3: o_upd_req, or o_done with o_nowin/o_err, is high in the cycle after E3.
- Ack sampled at edge Ea causes:
  - o_upd_req=0 and o_done=1 in the cycle after Ea.
  - o_ready=1 in that same cycle; a new accept is allowed at the next edge.
  - Minimum request duration is 1 cycle; a same-cycle ack is permitted.
- Nowin/err path: o_done and o_ready are both high in the same cycle, and back-to-back accept is allowed.
- Throughput is one decision per p_levels+1 cycles, plus the ack wait.

## Test plan
- **Valid winner:** p_levels=3, root=10, node2=01, node5=10 (others 01), value=50, thresh=10.
  - Expect o_upd_req 3 cycles after accept, o_winner_id=3'b101, o_onehot=8'b0010_0000.
  - Ack 4 cycles later: o_done pulses once and o_upd_req drops.
- **All zero:** root=00, all other codes 00, value=0.
  - Expect o_done with o_nowin=1, o_err=0, no o_upd_req, latency 3.
- **Below threshold:** same valid path as the first scenario, value=9, thresh=10.
  - Expect o_nowin=1, no request; equality (value=10) must produce a request.
- **Malformed path:** root=01, node1=11.
  - Expect o_err=1 at fixed latency 3 and no request.
  - Variant: node1=00 with root=01 also gives o_err.
- **Reset and ack edge cases:**
  - i_rst asserted during REQ: next cycle o_upd_req=0, o_onehot=0, o_ready=1, no o_done.
  - Ack pulsed during WALK is ignored.
- **Back-to-back:** i_valid held high with ack tied to 1.
  - Decisions complete every 5 cycles.
  - i_node_idx changed after accept does not alter the decoded ID.

Source files
------------

// File: rtl/winner_tree_decoder.sv
// Walks the argmax comparator tree from root to leaf to recover the winning neuron,
// applies the firing threshold and raises a req/ack update with a one-hot enable.
//
// state  | meaning
// S_IDLE | ready for a tree result; outputs of the last decision held
// S_WALK | one tree level examined per cycle, fixed p_levels cycles
// S_REQ  | update request to the neuron array, waiting for ack
module winner_tree_decoder #(
   parameter int p_width  = 21,
   parameter int p_levels = 3
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [2*((2**p_levels)-1)-1:0] i_node_idx,
   input  logic [p_width-1:0]            i_value,
   input  logic [p_width-1:0]            i_thresh,
   output logic                          o_upd_req,
   input  logic                          i_upd_ack,
   output logic [p_levels-1:0]           o_winner_id,
   output logic [(2**p_levels)-1:0]      o_onehot,
   output logic                          o_done,
   output logic                          o_nowin,
   output logic                          o_err
);

   localparam int N      = 2**p_levels;
   localparam int NODES  = N - 1;
   localparam int PTR_W  = p_levels + 1;
   localparam int LVL_W  = (p_levels > 1) ? $clog2(p_levels) : 1;
   localparam logic [N-1:0] ONE_LSB = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WALK = 2'd1,
      S_REQ  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [2*NODES-1:0]      node_q;
   logic                    below_q;
   logic [p_levels-1:0]     id_q;
   logic [PTR_W-1:0]        ptr_q;
   logic [LVL_W-1:0]        lvl_q;
   logic                    zero_q;
   logic                    err_q;

   logic [1:0]              code;
   logic                    last_lvl;
   logic [p_levels-1:0]     id_n;
   logic [PTR_W-1:0]        ptr_n;
   logic                    zero_n;
   logic                    err_n;

   assign o_ready = (state_q == S_IDLE);

   always_comb begin
      code = 2'b00;
      for (int k = 0; k < NODES; k++) begin
         if (ptr_q == PTR_W'(k)) begin
            code = node_q[2*k +: 2];
         end
      end
   end

   // Once zero or error is flagged the path freezes; the walk still runs to full depth.
   always_comb begin
      last_lvl = (lvl_q == LVL_W'(p_levels - 1));
      id_n     = id_q;
      ptr_n    = ptr_q;
      zero_n   = zero_q;
      err_n    = err_q;
      if (!(zero_q || err_q)) begin
         case (code)
            2'b01: begin
               id_n  = id_q << 1;
               ptr_n = (ptr_q << 1) + PTR_W'(1);
            end
            2'b10: begin
               id_n  = (id_q << 1) | p_levels'(1);
               ptr_n = (ptr_q << 1) + PTR_W'(2);
            end
            2'b00: begin
               if (lvl_q == '0) begin
                  zero_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: err_n = 1'b1;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         node_q      <= '0;
         below_q     <= 1'b0;
         id_q        <= '0;
         ptr_q       <= '0;
         lvl_q       <= '0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         o_upd_req   <= 1'b0;
         o_winner_id <= '0;
         o_onehot    <= '0;
         o_done      <= 1'b0;
         o_nowin     <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  node_q      <= i_node_idx;
                  below_q     <= (i_value < i_thresh);
                  id_q        <= '0;
                  ptr_q       <= '0;
                  lvl_q       <= '0;
                  zero_q      <= 1'b0;
                  err_q       <= 1'b0;
                  o_winner_id <= '0;
                  o_nowin     <= 1'b0;
                  o_err       <= 1'b0;
                  state_q     <= S_WALK;
               end
            end
            S_WALK: begin
               id_q   <= id_n;
               ptr_q  <= ptr_n;
               zero_q <= zero_n;
               err_q  <= err_n;
               lvl_q  <= lvl_q + LVL_W'(1);
               if (last_lvl) begin
                  if (err_n) begin
                     o_err   <= 1'b1;
                     o_done  <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (zero_n || below_q) begin
                     o_nowin <= 1'b1;
                     o_done  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     o_winner_id <= id_n;
                     o_upd_req   <= 1'b1;
                     o_onehot    <= ONE_LSB << id_n;
                     state_q     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (i_upd_ack) begin
                  o_upd_req <= 1'b0;
                  o_onehot  <= '0;
                  o_done    <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_winner_tree_decoder.sv
// Directed bench for winner_tree_decoder: a driver queues expected decisions,
// a negedge monitor pops and compares whenever a request or done appears.
module tb_winner_tree_decoder;
   localparam int p_width  = 21;
   localparam int p_levels = 3;
   localparam int N        = 8;
   localparam int NB       = 14;
   localparam int K_WIN    = 0;
   localparam int K_NOWIN  = 1;
   localparam int K_ERR    = 2;

   logic                i_clk = 1'b0;
   logic                i_rst = 1'b1;
   logic                i_valid = 1'b0;
   logic                i_upd_ack = 1'b0;
   logic [NB-1:0]       i_node_idx = '0;
   logic [p_width-1:0]  i_value = '0;
   logic [p_width-1:0]  i_thresh = '0;
   logic                o_ready;
   logic                o_upd_req;
   logic [p_levels-1:0] o_winner_id;
   logic [N-1:0]        o_onehot;
   logic                o_done;
   logic                o_nowin;
   logic                o_err;

   winner_tree_decoder #(.p_width(p_width), .p_levels(p_levels)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_node_idx(i_node_idx), .i_value(i_value), .i_thresh(i_thresh),
      .o_upd_req(o_upd_req), .i_upd_ack(i_upd_ack), .o_winner_id(o_winner_id),
      .o_onehot(o_onehot), .o_done(o_done), .o_nowin(o_nowin), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      int           kind;
      logic [2:0]   id;
      logic [7:0]   oh;
      int           acc;
   } exp_t;
   exp_t sb[$];

   bit         mon_en = 1'b0;
   logic       req_d = 1'b0;
   logic [2:0] last_id = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic flag_fail(input string name, input logic [31:0] act);
      n_chk++;
      $display("FAIL %s: observed %0h with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   function automatic logic [NB-1:0] mk(input logic [1:0] c0, c1, c2, c3, c4, c5, c6);
      return {c6, c5, c4, c3, c2, c1, c0};
   endfunction

   // Scoreboard monitor
   always @(negedge i_clk) begin
      exp_t e;
      if (mon_en) begin
         if (o_upd_req && !req_d) begin
            if (sb.size() == 0) flag_fail("unexpected_req", 32'(o_winner_id));
            else begin
               e = sb.pop_front();
               check("req_kind", 32'(e.kind), 32'(K_WIN));
               check("req_winner_id", 32'(o_winner_id), 32'(e.id));
               check("req_onehot", 32'(o_onehot), 32'(e.oh));
               check("req_latency", 32'(cyc), 32'(e.acc + 3));
               last_id = e.id;
            end
         end else if (o_done) begin
            if (req_d) begin
               check("ack_done_req_low", 32'(o_upd_req), 32'd0);
               check("ack_done_onehot", 32'(o_onehot), 32'd0);
               check("ack_done_id_kept", 32'(o_winner_id), 32'(last_id));
            end else if (sb.size() == 0) flag_fail("unexpected_done", 32'({o_nowin, o_err}));
            else begin
               e = sb.pop_front();
               check("done_nowin", 32'(o_nowin), 32'(e.kind == K_NOWIN));
               check("done_err", 32'(o_err), 32'(e.kind == K_ERR));
               check("done_no_req", 32'(o_upd_req), 32'd0);
               check("done_latency", 32'(cyc), 32'(e.acc + 3));
            end
         end
      end
      req_d = o_upd_req;
   end

   // Called and returns at a negedge.
   task automatic issue(input logic [NB-1:0] nodes, input logic [p_width-1:0] v, th,
                        input int kind, input logic [2:0] id, input logic [7:0] oh,
                        input bit keep_valid, input bit expect_out, output int acc);
      int t = 0;
      while (!o_ready && t < 40) begin
         @(negedge i_clk);
         t++;
      end
      acc = -1;
      if (!o_ready) begin
         check("ready_timeout", 32'(o_ready), 32'd1);
      end else begin
         i_valid    = 1'b1;
         i_node_idx = nodes;
         i_value    = v;
         i_thresh   = th;
         acc        = cyc + 1;
         if (expect_out) sb.push_back('{kind, id, oh, acc});
         @(negedge i_clk);
         i_node_idx = {NB{1'b1}};
         i_value    = '0;
         i_thresh   = {p_width{1'b1}};
         if (!keep_valid) i_valid = 1'b0;
      end
   endtask

   task automatic wait_req();
      int t = 0;
      while (!o_upd_req && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_upd_req) check("req_timeout", 32'(o_upd_req), 32'd1);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!o_done && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_done) check("done_timeout", 32'(o_done), 32'd1);
      else check("done_with_ready", 32'(o_ready), 32'd1);
   endtask

   task automatic do_ack(input int delay, input logic [7:0] oh);
      repeat (delay) begin
         @(negedge i_clk);
         check("req_held", 32'(o_upd_req), 32'd1);
         check("onehot_held", 32'(o_onehot), 32'(oh));
      end
      i_upd_ack = 1'b1;
      @(negedge i_clk);
      i_upd_ack = 1'b0;
      check("ack_req_drop", 32'(o_upd_req), 32'd0);
      check("ack_done_pulse", 32'(o_done), 32'd1);
      check("ack_ready", 32'(o_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NB-1:0] path5;
      logic [NB-1:0] all01;
      logic [NB-1:0] all10;
      logic [NB-1:0] path6;
      int acc;
      int prev_acc;

      path5 = mk(2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01);
      all01 = mk(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01);
      all10 = mk(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10);
      path6 = mk(2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01);

      repeat (3) @(negedge i_clk);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_req", 32'(o_upd_req), 32'd0);
      check("rst_flags", 32'({o_done, o_nowin, o_err}), 32'd0);
      check("rst_id", 32'(o_winner_id), 32'd0);
      check("rst_onehot", 32'(o_onehot), 32'd0);
      i_rst  = 1'b0;
      mon_en = 1'b1;

      // Valid winner, id 101
      issue(path5, 21'd50, 21'd10, K_WIN, 3'b101, 8'b0010_0000, 1'b0, 1'b1, acc);
      wait_req();
      do_ack(4, 8'b0010_0000);
      @(negedge i_clk);
      check("id_retained", 32'(o_winner_id), 32'd5);
      check("single_done", 32'(o_done), 32'd0);

      // All zero tree
      issue('0, 21'd0, 21'd0, K_NOWIN, 3'd0, 8'd0, 1'b0, 1'b1, acc);
      wait_done();

      // Below threshold, then equality
      issue(path5, 21'd9, 21'd10, K_NOWIN, 3'd0, 8'd0, 1'b0, 1'b1, acc);
      wait_done();
      issue(path5, 21'd10, 21'd10, K_WIN, 3'b101, 8'b0010_0000, 1'b0, 1'b1, acc);
      wait_req();
      do_ack(0, 8'b0010_0000);

      // Malformed paths; error wins over below-threshold
      issue(mk(2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01), 21'd50, 21'd10,
            K_ERR, 3'd0, 8'd0, 1'b0, 1'b1, acc);
      wait_done();
      issue(mk(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01), 21'd50, 21'd10,
            K_ERR, 3'd0, 8'd0, 1'b0, 1'b1, acc);
      wait_done();
      issue(mk(2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01), 21'd0, 21'd5,
            K_ERR, 3'd0, 8'd0, 1'b0, 1'b1, acc);
      wait_done();

      // Leaf extremes
      issue(all01, 21'd1, 21'd0, K_WIN, 3'b000, 8'b0000_0001, 1'b0, 1'b1, acc);
      wait_req();
      do_ack(1, 8'b0000_0001);
      issue(all10, 21'h1FFFFF, 21'h1FFFFF, K_WIN, 3'b111, 8'b1000_0000, 1'b0, 1'b1, acc);
      wait_req();
      do_ack(2, 8'b1000_0000);

      // Ack during WALK is ignored
      issue(path5, 21'd50, 21'd10, K_WIN, 3'b101, 8'b0010_0000, 1'b0, 1'b1, acc);
      i_upd_ack = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_upd_ack = 1'b0;
      wait_req();
      do_ack(3, 8'b0010_0000);

      // Reset during REQ
      issue(path6, 21'd7, 21'd3, K_WIN, 3'b110, 8'b0100_0000, 1'b0, 1'b1, acc);
      wait_req();
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      check("rstreq_req", 32'(o_upd_req), 32'd0);
      check("rstreq_onehot", 32'(o_onehot), 32'd0);
      check("rstreq_ready", 32'(o_ready), 32'd1);
      check("rstreq_done", 32'(o_done), 32'd0);
      check("rstreq_id", 32'(o_winner_id), 32'd0);

      // Reset mid-WALK: no completion at all
      issue(all01, 21'd1, 21'd0, K_WIN, 3'd0, 8'd0, 1'b0, 1'b0, acc);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      check("rstwalk_ready", 32'(o_ready), 32'd1);
      repeat (5) @(negedge i_clk);
      check("rstwalk_no_req", 32'(o_upd_req), 32'd0);

      // Back-to-back with ack tied high and valid held
      i_upd_ack = 1'b1;
      issue(path5, 21'd50, 21'd10, K_WIN, 3'b101, 8'b0010_0000, 1'b1, 1'b1, acc);
      prev_acc = acc;
      issue(all01, 21'd1, 21'd0, K_WIN, 3'b000, 8'b0000_0001, 1'b1, 1'b1, acc);
      check("b2b_spacing1", 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
      issue(path6, 21'd8, 21'd8, K_WIN, 3'b110, 8'b0100_0000, 1'b0, 1'b1, acc);
      check("b2b_spacing2", 32'(acc - prev_acc), 32'd5);
      wait_req();
      @(negedge i_clk);
      check("b2b_last_done", 32'(o_done), 32'd1);
      i_upd_ack = 1'b0;

      repeat (4) @(negedge i_clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
